gate_cmp_capture: RTL
=====================

Name: gate_cmp_capture

Overview:
- Synthesizable response-side checker for exhaustive gate tests; the counterpart of a stimulus sequencer.
- A sequencer presents one test vector per handshake: a stimulus index plus the spec and impl output words.
- The block compares the two words, counts vectors and mismatches, and buffers the first DEPTH mismatch records in a FIFO. A host drains the FIFO through a valid/ready read port.
- It sits between the stimulus sequencer and the result readout in the systest harness.

Parameters:
- NOUT, 22, width of the spec/impl output words (one bit per gate output).
- IDXW, 6, width of the stimulus index (64 vectors = 4^3).
- DEPTH, 4, mismatch FIFO entries; power of two, minimum 2.
- CNTW, 16, width of the vector and mismatch counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears counters and FIFO and enters RUN.
- vec_valid  in  1  sequencer has a vector.
- vec_ready  out  1  checker accepts the vector this cycle.
- vec_last  in  1  qualifies the final vector of the sweep.
- vec_idx  in  IDXW  stimulus index of the vector.
- spec_bits  in  NOUT  reference outputs.
- impl_bits  in  NOUT  implementation outputs.
- rd_valid  out  1  mismatch record available.
- rd_ready  in  1  host pops the record.
- rd_idx  out  IDXW  index of the head record.
- rd_diff  out  NOUT  spec_bits XOR impl_bits of the head record.
- vec_cnt  out  CNTW  vectors accepted.
- err_cnt  out  CNTW  mismatching vectors accepted (saturating).
- overflow  out  1  sticky; a mismatch was dropped because the FIFO was full.
- done  out  1  high in DONE state.

Behaviour:
- Reset: state IDLE. vec_ready=0, rd_valid=0, rd_idx=0, rd_diff=0, vec_cnt=0, err_cnt=0, overflow=0, done=0. FIFO pointers zeroed.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start -> RUN.
  - RUN: an accepted vector with vec_last=1 -> DONE.
  - DONE: start -> RUN.
  - start in RUN is ignored. rst wins over everything, including mid-RUN.
- On start: vec_cnt, err_cnt, overflow, done and the FIFO clear in the same edge.
- vec_ready = (state==RUN), registered-free combinational decode of state. Never asserted in IDLE or DONE.
- Accept = vec_valid & vec_ready.
- On accept:
  - vec_cnt += 1, wrapping at 2^CNTW.
  - diff = spec_bits ^ impl_bits.
  - If diff != 0: err_cnt += 1, saturating at all-ones. If the FIFO is not full, push {vec_idx, diff}; else set overflow.
  - Acceptance never stalls on a full FIFO.
- Result latency: counters reflect an accepted vector on the next cycle. A pushed record appears on rd_valid on the next cycle.
- FIFO:
  - rd_valid = !empty; rd_idx/rd_diff show the head entry.
  - Pop when rd_valid & rd_ready.
  - A simultaneous push and pop when full is allowed: the push succeeds and overflow is not set.
  - Pointers are log2(DEPTH)+1 bits; wrap-around is handled by the extra MSB.
- The FIFO stays readable in DONE and IDLE. Only start or rst clears it.
- done = (state==DONE).

Optional Feature:
- Macro: GATE_CMP_SIGNATURE_EN.
- Defined:
  - Adds output sig [31:0].
  - A 32-bit MISR with polynomial 0x04C11DB7 runs over impl_bits zero-extended to 32 (NOUT ≤ 32).
  - Updated on every accept; seed 0xFFFFFFFF on rst and start.
- Undefined: no sig port, no MISR logic.

Decomposition:
- Package gate_cmp_pkg: state enum (IDLE=0, RUN=1, DONE=2), MISR polynomial and seed constants, record struct {idx, diff}.
- Sub-module gate_cmp_fifo: parameterized sync FIFO with push/pop/full/empty; the top holds the FSM, counters and MISR.

Test Plan:
- Clean sweep: start, then 64 vectors idx 0..63 with spec==impl, last on 63 -> vec_cnt=64, err_cnt=0, rd_valid=0, done=1, overflow=0.
- Single fault: idx 17 with impl_bits = spec_bits ^ 22'h000004 -> err_cnt=1; record rd_idx=17, rd_diff=22'h000004; popping it drops rd_valid.
- Overflow: DEPTH=4, 6 consecutive mismatches idx 0..5, no reads -> err_cnt=6, overflow=1, FIFO holds idx 0..3 in order.
- Full + simultaneous pop/push: FIFO full, rd_ready=1 while mismatch idx 9 arrives -> overflow stays 0, tail record idx 9.
- Reset mid-RUN: rst after 10 vectors -> all outputs at reset values next cycle, vec_ready=0 until start.
- With GATE_CMP_SIGNATURE_EN: all-zero impl_bits for 1 vector after start -> sig equals the golden MISR step from 0xFFFFFFFF; rerunning after start reproduces it.

Source files
------------

// File: rtl/gate_cmp_pkg.sv
// Shared types and constants for the gate test response checker.
// FSM state encoding, MISR constants and the mismatch record layout.
package gate_cmp_pkg;

   localparam int NOUT_DEF  = 22;
   localparam int IDXW_DEF  = 6;
   localparam int DEPTH_DEF = 4;
   localparam int CNTW_DEF  = 16;

   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [IDXW_DEF-1:0] idx;
      logic [NOUT_DEF-1:0] diff;
   } rec_t;

   // One MISR clock: shift with polynomial feedback, then fold in the data word.
   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
      misr_step = {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0000_0000) ^ d;
   endfunction

endpackage

// File: rtl/gate_cmp_capture_if.sv
// Vector handshake and mismatch read port between sequencer, checker and host.
interface gate_cmp_capture_if #(
   parameter int NOUT = 22,
   parameter int IDXW = 6
);
   logic            vec_valid;
   logic            vec_ready;
   logic            vec_last;
   logic [IDXW-1:0] vec_idx;
   logic [NOUT-1:0] spec_bits;
   logic [NOUT-1:0] impl_bits;
   logic            rd_valid;
   logic            rd_ready;
   logic [IDXW-1:0] rd_idx;
   logic [NOUT-1:0] rd_diff;

   modport master (
      output vec_valid, vec_last, vec_idx, spec_bits, impl_bits, rd_ready,
      input  vec_ready, rd_valid, rd_idx, rd_diff
   );

   modport slave (
      input  vec_valid, vec_last, vec_idx, spec_bits, impl_bits, rd_ready,
      output vec_ready, rd_valid, rd_idx, rd_diff
   );
endinterface

// File: rtl/gate_cmp_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head data reads as zero while empty.
module gate_cmp_fifo #(
   parameter int W     = 28,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic         do_push, do_pop;

   // Status flags and head word.
   always_comb begin
      empty = (wr_q == rd_q);
      full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];
   end

   // A push into a full FIFO succeeds only when a pop frees the slot in the same cycle.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d   = mem_q;
      if (clr) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         wr_d = do_push ? wr_q + (AW+1)'(1) : wr_q;
         rd_d = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
         if (do_push) begin
            mem_d[wr_q[AW-1:0]] = din;
         end else begin
            mem_d = mem_q;
         end
      end
   end

   // Pointer and storage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         mem_q <= '{default: '0};
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end
endmodule

// File: rtl/gate_cmp_capture.sv
// Response checker: compares spec/impl words, counts vectors and mismatches, queues mismatch records.
// Build option GATE_CMP_SIGNATURE_EN adds a 32-bit MISR signature over impl_bits on port sig.
module gate_cmp_capture
   import gate_cmp_pkg::*;
#(
   parameter int NOUT  = NOUT_DEF,
   parameter int IDXW  = IDXW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNTW  = CNTW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   gate_cmp_capture_if.slave bus,
   output logic [CNTW-1:0] vec_cnt,
   output logic [CNTW-1:0] err_cnt,
   output logic            overflow,
   output logic            done
`ifdef GATE_CMP_SIGNATURE_EN
   ,
   output logic [31:0]     sig
`endif
);
   localparam int RW = IDXW + NOUT;

   state_e          state_q, state_d;
   logic [CNTW-1:0] vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
   logic            overflow_q, overflow_d;
   logic            accept, clr, mism, pop, fifo_full, fifo_empty;
   logic [NOUT-1:0] diff;
   logic [RW-1:0]   head;

   // Handshake decode; start is only honoured outside RUN.
   always_comb begin
      accept = bus.vec_valid && (state_q == RUN);
      clr    = start && (state_q != RUN);
      diff   = bus.spec_bits ^ bus.impl_bits;
      mism   = accept && (diff != '0);
      pop    = bus.rd_ready && !fifo_empty;
   end

   // Next-state logic for the FSM, counters and the sticky overflow.
   always_comb begin
      case (state_q)
         IDLE:    if (start) state_d = RUN; else state_d = IDLE;
         RUN:     if (accept && bus.vec_last) state_d = DONE; else state_d = RUN;
         DONE:    if (start) state_d = RUN; else state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (clr) begin
         vec_cnt_d  = '0;
         err_cnt_d  = '0;
         overflow_d = 1'b0;
      end else begin
         vec_cnt_d = accept ? vec_cnt_q + CNTW'(1) : vec_cnt_q;
         if (mism && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNTW'(1);
         end else begin
            err_cnt_d = err_cnt_q;
         end
         overflow_d = overflow_q || (mism && fifo_full && !pop);
      end
   end

   // FSM and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         vec_cnt_q  <= '0;
         err_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_cnt_q  <= vec_cnt_d;
         err_cnt_q  <= err_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   gate_cmp_fifo #(
      .W     (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (mism),
      .pop   (pop),
      .din   ({bus.vec_idx, diff}),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.vec_ready = (state_q == RUN);
   assign bus.rd_valid  = !fifo_empty;
   assign bus.rd_idx    = head[RW-1:NOUT];
   assign bus.rd_diff   = head[NOUT-1:0];
   assign vec_cnt       = vec_cnt_q;
   assign err_cnt       = err_cnt_q;
   assign overflow      = overflow_q;
   assign done          = (state_q == DONE);

`ifdef GATE_CMP_SIGNATURE_EN
   logic [31:0] sig_q, sig_d;

   // Signature reseeds with the counters and advances on every accepted vector.
   always_comb begin
      if (clr) begin
         sig_d = MISR_SEED;
      end else if (accept) begin
         sig_d = misr_step(sig_q, 32'(bus.impl_bits));
      end else begin
         sig_d = sig_q;
      end
   end

   // Signature register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= MISR_SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;
`endif
endmodule
